// File: rtl/vpu_pkg.sv
// Shared constants and types for the vector load path.
// IDX_W sizes the lane counters so they run 0..LANES-1.
package vpu_pkg;
   localparam int LANES  = 16;
   localparam int ADDR_W = 16;
   localparam int REG_W  = 5;
   localparam int IDX_W  = $clog2(LANES);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} vls_state_t;
endpackage

// File: rtl/vector_load_sequencer_if.sv
// Request, memory-read and collect signals of the vector load sequencer.
// master is the sequencer side; slave is the pipeline/memory/output-manager side.
interface vector_load_sequencer_if;
   import vpu_pkg::*;

   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [REG_W-1:0]  RD_in;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic              collect_en;
   logic [IDX_W-1:0]  collect_idx;
   logic [REG_W-1:0]  RD_out;
   logic              busy;
   logic              done;

   modport master (
      input  start, base_addr, RD_in,
      output mem_addr, mem_rd_en, collect_en, collect_idx, RD_out, busy, done
   );

   modport slave (
      output start, base_addr, RD_in,
      input  mem_addr, mem_rd_en, collect_en, collect_idx, RD_out, busy, done
   );
endinterface

// File: rtl/valid_delay_line.sv
// 1-bit shift register of DEPTH stages with synchronous clear.
// Clearing drops every in-flight valid so nothing emerges after a reset.
module valid_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q
);
   logic [DEPTH-1:0] pipe_reg;

   always_ff @(posedge clk) begin
      if (clr) begin
         pipe_reg <= '0;
      end else begin
         // Drop the oldest stage, shift the new valid into bit 0.
         pipe_reg <= DEPTH'({pipe_reg, d});
      end
   end

   assign q = pipe_reg[DEPTH-1];
endmodule

// File: rtl/vector_load_sequencer.sv
// Issues LANES consecutive reads from base_addr and tracks their return,
// holding busy until the last word has been collected.
module vector_load_sequencer
   import vpu_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   vector_load_sequencer_if.master        bus
);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

   vls_state_t        state_reg;
   logic [ADDR_W-1:0] base_reg;
   logic [IDX_W-1:0]  issue_cnt_reg;
   logic [IDX_W-1:0]  collect_idx_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic              mem_rd_en_reg;
   logic [REG_W-1:0]  rd_reg;
   logic              busy_reg;
   logic              done_reg;
   logic              collect_en;

   valid_delay_line #(.DEPTH(MEM_LAT)) u_valid_delay (
      .clk (clk),
      .clr (rst),
      .d   (mem_rd_en_reg),
      .q   (collect_en)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         base_reg        <= '0;
         issue_cnt_reg   <= '0;
         collect_idx_reg <= '0;
         mem_addr_reg    <= '0;
         mem_rd_en_reg   <= 1'b0;
         rd_reg          <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         if (collect_en) begin
            collect_idx_reg <= collect_idx_reg + 1'b1;
         end
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (bus.start) begin
                  base_reg        <= bus.base_addr;
                  rd_reg          <= bus.RD_in;
                  issue_cnt_reg   <= '0;
                  collect_idx_reg <= '0;
                  mem_addr_reg    <= bus.base_addr;
                  mem_rd_en_reg   <= 1'b1;
                  busy_reg        <= 1'b1;
                  state_reg       <= ISSUE;
               end
            end
            ISSUE: begin
               if (issue_cnt_reg == LAST_IDX) begin
                  mem_rd_en_reg <= 1'b0;
                  mem_addr_reg  <= '0;
                  state_reg     <= DRAIN;
               end else begin
                  issue_cnt_reg <= issue_cnt_reg + 1'b1;
                  // Address wraps modulo 2^ADDR_W by construction of the adder width.
                  mem_addr_reg  <= base_reg + ADDR_W'(issue_cnt_reg) + ADDR_W'(1);
               end
            end
            DRAIN: begin
               if (collect_en && (collect_idx_reg == LAST_IDX)) begin
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               done_reg        <= 1'b0;
               busy_reg        <= 1'b0;
               collect_idx_reg <= '0;
               state_reg       <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_addr    = mem_addr_reg;
   assign bus.mem_rd_en   = mem_rd_en_reg;
   assign bus.collect_en  = collect_en;
   assign bus.collect_idx = collect_idx_reg;
   assign bus.RD_out      = rd_reg;
   assign bus.busy        = busy_reg;
   assign bus.done        = done_reg;
endmodule
